// File: rtl/ps2_key_capture.sv
// ps2_key_capture: PS/2 keyboard receiver that holds the last pressed scan code and a BCD press count.
//   clk       system clock
//   clrn      asynchronous active-low reset
//   ps2_clk   keyboard clock, asynchronous to clk
//   ps2_data  keyboard data, asynchronous to clk
//   code_hi   upper nibble of last pressed scan code
//   code_lo   lower nibble of last pressed scan code
//   cnt_tens  BCD tens digit of the press count
//   cnt_ones  BCD ones digit of the press count
//   key_down  high while a key is held
//   frame_err 1-clk pulse on a bad or aborted frame
module ps2_key_capture #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] code_hi,
    output logic [3:0] code_lo,
    output logic [3:0] cnt_tens,
    output logic [3:0] cnt_ones,
    output logic       key_down,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, HELD, BRK} state_t;

    state_t state, state_n;
    logic [2:0] clk_s;
    logic [1:0] dat_s;
    logic [10:0] sr;
    logic [3:0] bit_cnt;
    logic [TW-1:0] to_cnt;
    logic done, fall, to_hit, good, byte_rdy, inc;
    logic [7:0] code, code_n;
    logic key_down_n;
    logic [3:0] tens_n, ones_n;

    assign fall     = clk_s[2] & ~clk_s[1];
    assign to_hit   = to_cnt == TW'(TIMEOUT_CYCLES);
    // sr holds {stop, parity, d7..d0, start} once the 11th bit has shifted in
    assign good     = ~sr[0] & sr[10] & (^sr[9:1]);
    assign byte_rdy = done & good;
    assign frame_err = (done & ~good) | to_hit;
    assign code_hi  = code[7:4];
    assign code_lo  = code[3:0];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_s   <= 3'b111;
            dat_s   <= 2'b11;
            sr      <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
            done    <= 1'b0;
        end else begin
            clk_s <= {clk_s[1:0], ps2_clk};
            dat_s <= {dat_s[0], ps2_data};
            done  <= 1'b0;
            // a timeout takes priority over a coincident fall, which is dropped
            if (to_hit) begin
                bit_cnt <= '0;
                to_cnt  <= '0;
            end else if (fall) begin
                sr      <= {dat_s[1], sr[10:1]};
                to_cnt  <= '0;
                done    <= bit_cnt == 4'd10;
                bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
            end else if (bit_cnt != 4'd0) begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            code     <= '0;
            key_down <= 1'b0;
            cnt_tens <= '0;
            cnt_ones <= '0;
        end else begin
            state    <= state_n;
            code     <= code_n;
            key_down <= key_down_n;
            cnt_tens <= tens_n;
            cnt_ones <= ones_n;
        end
    end

    always_comb begin
        state_n    = state;
        code_n     = code;
        key_down_n = key_down;
        inc        = 1'b0;
        if (byte_rdy) begin
            if (state == BRK) begin
                key_down_n = 1'b0;
                state_n    = IDLE;
            end else if (sr[8:1] == 8'hF0) begin
                state_n = BRK;
            end else if (state == IDLE || sr[8:1] != code) begin
                code_n     = sr[8:1];
                key_down_n = 1'b1;
                state_n    = HELD;
                inc        = 1'b1;
            end
        end
        ones_n = inc ? ((cnt_ones == 4'd9) ? 4'd0 : cnt_ones + 4'd1) : cnt_ones;
        tens_n = (inc && cnt_ones == 4'd9) ? ((cnt_tens == 4'd9) ? 4'd0 : cnt_tens + 4'd1) : cnt_tens;
    end
endmodule
